game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win; legal range 1..15.
REQ-002 Parameter SERVE_DLY, default 60, clk1 ticks of freeze after each point; legal range 1..1023.
REQ-003 clk1  in  1  game tick clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low; clock clk1.
REQ-005 start  in  1  raw start push-button, asynchronous to clk1, active-high.
REQ-006 p1s  in  4  player 1 score from ball logic.
REQ-007 p2s  in  4  player 2 score from ball logic.
REQ-008 game_state  out  2  00 IDLE, 01 PLAY, 10 SERVE, 11 OVER; ball moves only at 01.
REQ-009 winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw.
REQ-010 score_clr_n  out  1  active-low one-tick pulse that clears ball position and scores.
REQ-011 serve_cnt  out  10  remaining SERVE ticks, for display.

Function
REQ-012 start SHALL pass through a 2-flop synchronizer plus a delay flop; start_rise = sync2 & ~sync3.
REQ-013 Score change SHALL be detected against registers p1s_q/p2s_q, which load p1s/p2s every tick in every state.
REQ-014 p1_pt = (p1s != p1s_q); p2_pt = (p2s != p2s_q); both SHALL be ignored outside PLAY.
REQ-015 IDLE: on start_rise, go to PLAY next edge; otherwise stay.
REQ-016 PLAY: on p1_pt or p2_pt, go to OVER if either input score >= WIN_SCORE, else go to SERVE with serve_cnt loaded with SERVE_DLY.
REQ-017 PLAY: start_rise with no point SHALL be ignored.
REQ-018 SERVE: serve_cnt decrements by 1 per tick; the tick on which serve_cnt == 1 SHALL move to PLAY with serve_cnt = 0.
REQ-019 SERVE: score changes and start_rise SHALL be ignored.
REQ-020 OVER: winner latched on entry: 01 if only p1s >= WIN_SCORE, 10 if only p2s >= WIN_SCORE, 11 if both.
REQ-021 OVER: on start_rise, go to IDLE, clear winner to 00, and drive score_clr_n low for exactly that one following tick.
REQ-022 Both points in the same PLAY tick SHALL be treated as one event; the win check uses both scores.
REQ-023 Score comparisons SHALL be 4-bit unsigned; a score of 0 after wrap SHALL not count as a win.
REQ-024 All outputs SHALL be registered; game_state reflects the state register with no combinational path from inputs.
REQ-025 Latency: start high at edge N gives start_rise after edge N+1, and the state changes at edge N+2.
REQ-026 Latency: a score change visible at edge N gives the state change at edge N+1.

Reset
REQ-027 With reset low at an edge: state IDLE, winner 00, serve_cnt 0, score_clr_n 1, sync flops 0, p1s_q/p2s_q loaded with the current p1s/p2s.
REQ-028 Reset SHALL take effect from any state, including mid-SERVE countdown; no score_clr_n pulse is issued on reset.

Structure
REQ-029 Package game_pkg SHALL hold the state encodings (IDLE/PLAY/SERVE/OVER), the winner encodings and the WIN_SCORE/SERVE_DLY defaults.
REQ-030 Sub-module btn_sync SHALL implement the synchronizer and rise detect of REQ-012; the rest is a single FSM in game_ctrl.

Verification (WIN_SCORE=3, SERVE_DLY=4)
REQ-031 Reset low 2 ticks, then start pulsed high 1 tick -> game_state 00 until the 2nd edge after sampling, then 01.
REQ-032 In PLAY, p1s 0->1 -> game_state 10 next edge; serve_cnt 4,3,2,1; game_state 01 on the following edge.
REQ-033 In PLAY, p2s 2->3 -> game_state 11, winner 10; start pulse -> game_state 00, winner 00, score_clr_n low exactly 1 tick.
REQ-034 In PLAY, p1s 2->3 and p2s 2->3 on the same tick -> game_state 11, winner 11.
REQ-035 In SERVE with serve_cnt 2, p1s changes and start pulses -> both ignored; PLAY entered on schedule.
REQ-036 In SERVE with serve_cnt 3, reset low -> game_state 00, serve_cnt 0, score_clr_n stays 1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings and parameter defaults for the game controller.
package game_pkg;

   localparam int DEF_WIN_SCORE = 7;
   localparam int DEF_SERVE_DLY = 60;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PLAY  = 2'b01,
      ST_SERVE = 2'b10,
      ST_OVER  = 2'b11
   } game_state_e;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10,
      WIN_DRAW = 2'b11
   } winner_e;

   function automatic winner_e win_code(input logic p1_win, input logic p2_win);
      case ({p2_win, p1_win})
         2'b01:   return WIN_P1;
         2'b10:   return WIN_P2;
         2'b11:   return WIN_DRAW;
         default: return WIN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/game_ctrl_btn_sync.sv
// Two-flop synchronizer plus delay flop for the start button; rise is a one-tick pulse.
module btn_sync (
   input  logic clk1,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   logic sync1_q, sync2_q, sync3_q;
   logic sync1_d, sync2_d, sync3_d;

   always_comb begin
      sync1_d = btn;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
   end

   always_ff @(posedge clk1) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         sync3_q <= sync3_d;
      end
   end

   assign rise = sync2_q & ~sync3_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencing FSM: IDLE -> PLAY -> SERVE/OVER, with serve freeze countdown and winner latch.
module game_ctrl
   import game_pkg::*;
#(
   parameter int WIN_SCORE = DEF_WIN_SCORE,
   parameter int SERVE_DLY = DEF_SERVE_DLY
) (
   input  logic       clk1,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] p1s,
   input  logic [3:0] p2s,
   output logic [1:0] game_state,
   output logic [1:0] winner,
   output logic       score_clr_n,
   output logic [9:0] serve_cnt
);

   localparam logic [3:0] WIN_L   = 4'(WIN_SCORE);
   localparam logic [9:0] SERVE_L = 10'(SERVE_DLY);

   game_state_e state_q, state_d;
   winner_e     winner_q, winner_d;
   logic [9:0]  serve_cnt_q, serve_cnt_d;
   logic        score_clr_n_q, score_clr_n_d;
   logic [3:0]  p1s_q, p2s_q;
   logic        start_rise;
   logic        p1_pt, p2_pt, p1_win, p2_win;

   btn_sync u_btn_sync (
      .clk1  (clk1),
      .reset (reset),
      .btn   (start),
      .rise  (start_rise)
   );

   assign p1_pt  = (p1s != p1s_q);
   assign p2_pt  = (p2s != p2s_q);
   assign p1_win = (p1s >= WIN_L);
   assign p2_win = (p2s >= WIN_L);

   always_comb begin
      state_d       = state_q;
      winner_d      = winner_q;
      serve_cnt_d   = serve_cnt_q;
      score_clr_n_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (start_rise) state_d = ST_PLAY;
            else            state_d = ST_IDLE;
         end
         ST_PLAY: begin
            // simultaneous points collapse into one event judged on both scores
            if (p1_pt || p2_pt) begin
               if (p1_win || p2_win) begin
                  state_d  = ST_OVER;
                  winner_d = win_code(p1_win, p2_win);
               end else begin
                  state_d     = ST_SERVE;
                  serve_cnt_d = SERVE_L;
               end
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_SERVE: begin
            // <= 1 also recovers from a stray zero count
            if (serve_cnt_q <= 10'd1) begin
               state_d     = ST_PLAY;
               serve_cnt_d = 10'd0;
            end else begin
               serve_cnt_d = serve_cnt_q - 10'd1;
            end
         end
         ST_OVER: begin
            if (start_rise) begin
               state_d       = ST_IDLE;
               winner_d      = WIN_NONE;
               score_clr_n_d = 1'b0;
            end else begin
               state_d = ST_OVER;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            winner_d    = WIN_NONE;
            serve_cnt_d = 10'd0;
         end
      endcase
   end

   always_ff @(posedge clk1) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         winner_q      <= WIN_NONE;
         serve_cnt_q   <= 10'd0;
         score_clr_n_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         winner_q      <= winner_d;
         serve_cnt_q   <= serve_cnt_d;
         score_clr_n_q <= score_clr_n_d;
      end
   end

   // score history follows the inputs every tick, in reset too
   always_ff @(posedge clk1) begin
      p1s_q <= p1s;
      p2s_q <= p2s;
   end

   assign game_state  = state_q;
   assign winner      = winner_q;
   assign serve_cnt   = serve_cnt_q;
   assign score_clr_n = score_clr_n_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed-vector bench for game_ctrl with WIN_SCORE=3, SERVE_DLY=4.
module tb_game_ctrl;

   logic       clk1;
   logic       reset;
   logic       start;
   logic [3:0] p1s, p2s;
   logic [1:0] game_state, winner;
   logic       score_clr_n;
   logic [9:0] serve_cnt;

   int n_run  = 0;
   int n_fail = 0;

   game_ctrl #(.WIN_SCORE(3), .SERVE_DLY(4)) dut (
      .clk1        (clk1),
      .reset       (reset),
      .start       (start),
      .p1s         (p1s),
      .p2s         (p2s),
      .game_state  (game_state),
      .winner      (winner),
      .score_clr_n (score_clr_n),
      .serve_cnt   (serve_cnt)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // start high for one tick; state reaches PLAY on the second edge after sampling
   task automatic start_game();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("start_play", 16'(game_state), 16'h1);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      p1s   = 4'd0;
      p2s   = 4'd0;
      tick();
      tick();
      check("rst_state", 16'(game_state), 16'h0);
      check("rst_winner", 16'(winner), 16'h0);
      check("rst_cnt", 16'(serve_cnt), 16'h0);
      check("rst_clr", 16'(score_clr_n), 16'h1);
      reset = 1'b1;

      // start latency: two edges after sampling
      start = 1'b1;
      tick();
      start = 1'b0;
      check("lat_e0", 16'(game_state), 16'h0);
      tick();
      check("lat_e1", 16'(game_state), 16'h0);
      tick();
      check("lat_e2", 16'(game_state), 16'h1);

      // point without win -> SERVE countdown 4,3,2,1 then PLAY
      p1s = 4'd1;
      for (int i = 4; i >= 1; i--) begin
         tick();
         check("serve_state", 16'(game_state), 16'h2);
         check("serve_cnt", 16'(serve_cnt), 16'(i));
      end
      tick();
      check("serve_end_state", 16'(game_state), 16'h1);
      check("serve_end_cnt", 16'(serve_cnt), 16'h0);

      // score change and start during SERVE are ignored
      p2s = 4'd1;
      tick();
      tick();
      tick();
      check("ign_cnt2", 16'(serve_cnt), 16'h2);
      p1s   = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ign_cnt1", 16'(serve_cnt), 16'h1);
      check("ign_state", 16'(game_state), 16'h2);
      tick();
      check("ign_play", 16'(game_state), 16'h1);
      tick();
      check("play_start_ign", 16'(game_state), 16'h1);
      tick();
      check("play_hold", 16'(game_state), 16'h1);

      // reset mid-SERVE
      p2s = 4'd2;
      tick();
      tick();
      check("mid_cnt3", 16'(serve_cnt), 16'h3);
      reset = 1'b0;
      tick();
      check("mid_rst_state", 16'(game_state), 16'h0);
      check("mid_rst_cnt", 16'(serve_cnt), 16'h0);
      check("mid_rst_clr", 16'(score_clr_n), 16'h1);
      reset = 1'b1;
      tick();
      check("post_rst_clr", 16'(score_clr_n), 16'h1);
      check("post_rst_state", 16'(game_state), 16'h0);

      // simultaneous winning points -> draw
      start_game();
      p1s = 4'd3;
      p2s = 4'd3;
      tick();
      check("draw_state", 16'(game_state), 16'h3);
      check("draw_winner", 16'(winner), 16'h3);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("over_wait_state", 16'(game_state), 16'h3);
      check("over_wait_clr", 16'(score_clr_n), 16'h1);
      tick();
      check("clr_state", 16'(game_state), 16'h0);
      check("clr_winner", 16'(winner), 16'h0);
      check("clr_pulse", 16'(score_clr_n), 16'h0);
      tick();
      check("clr_release", 16'(score_clr_n), 16'h1);

      // player 2 wins; scores set during IDLE do not count
      p1s = 4'd0;
      p2s = 4'd2;
      tick();
      check("idle_ign", 16'(game_state), 16'h0);
      start_game();
      p2s = 4'd3;
      tick();
      check("p2_state", 16'(game_state), 16'h3);
      check("p2_winner", 16'(winner), 16'h2);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("p2_clr", 16'(score_clr_n), 16'h0);
      check("p2_idle_win", 16'(winner), 16'h0);
      tick();
      check("p2_clr_rel", 16'(score_clr_n), 16'h1);

      // wrap to 0 is a point but not a win; then player 1 wins
      p1s = 4'd15;
      p2s = 4'd0;
      tick();
      start_game();
      p1s = 4'd0;
      tick();
      check("wrap_state", 16'(game_state), 16'h2);
      check("wrap_winner", 16'(winner), 16'h0);
      for (int i = 0; i < 4; i++) tick();
      check("wrap_play", 16'(game_state), 16'h1);
      p1s = 4'd3;
      tick();
      check("p1_state", 16'(game_state), 16'h3);
      check("p1_winner", 16'(winner), 16'h1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
